// File: rtl/writeback_queue.sv
// Writeback queue: gathers up to two results per cycle (load path first, then
// ALU), keeps them in program order, and drains one register-file write per
// cycle. A combinational lookup exposes the youngest pending value for a
// register so hazard logic can forward it before it is committed.
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              writeback_clk_x70,
  input  logic              rst_n_x70,
  input  logic              mem_valid_x70,
  input  logic [ADDR_W-1:0] mem_dest_x70,
  input  logic [DATA_W-1:0] mem_data_x70,
  input  logic              alu_valid_x70,
  input  logic [ADDR_W-1:0] alu_dest_x70,
  input  logic [DATA_W-1:0] alu_data_x70,
  output logic              stall_x70,
  output logic              reg_write_en_x70,
  output logic [ADDR_W-1:0] reg_write_dest_x70,
  output logic [DATA_W-1:0] reg_write_data_x70,
  input  logic [ADDR_W-1:0] lookup_addr_x70,
  output logic              lookup_hit_x70,
  output logic [DATA_W-1:0] lookup_data_x70,
  output logic [CNT_W-1:0]  count_x70,
  output logic              overflow_x70
);

  logic [ADDR_W-1:0] dest_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  alu_ptr;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              wen_q;
  logic [ADDR_W-1:0] wdest_q;
  logic [DATA_W-1:0] wdata_q;

  logic              stall;
  logic              mem_push, alu_push, pop;

  // Stall only depends on registered occupancy, so it is glitch-free upstream.
  // Threshold DEPTH-1 leaves room for a dual push with no pop.
  assign stall    = (count_q >= CNT_W'(DEPTH - 1));
  assign mem_push = mem_valid_x70 && (mem_dest_x70 != '0) && !stall;
  assign alu_push = alu_valid_x70 && (alu_dest_x70 != '0) && !stall;
  assign pop      = (count_q != '0);
  // The ALU result lands behind the load result when both push.
  assign alu_ptr  = wr_ptr_q + PTR_W'(mem_push);

  // Next-state for pointers, occupancy and the sticky protocol error.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(mem_push) + PTR_W'(alu_push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
    overflow_d = overflow_q | (stall & (mem_valid_x70 | alu_valid_x70));
  end

  // Control state and the registered register-file write port.
  always_ff @(posedge writeback_clk_x70) begin
    if (!rst_n_x70) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      wen_q      <= 1'b0;
      wdest_q    <= '0;
      wdata_q    <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      wen_q      <= pop;
      if (pop) begin
        wdest_q <= dest_mem[rd_ptr_q];
        wdata_q <= data_mem[rd_ptr_q];
      end
    end
  end

  // FIFO storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge writeback_clk_x70) begin
    if (mem_push) begin
      dest_mem[wr_ptr_q] <= mem_dest_x70;
      data_mem[wr_ptr_q] <= mem_data_x70;
    end
    if (alu_push) begin
      dest_mem[alu_ptr] <= alu_dest_x70;
      data_mem[alu_ptr] <= alu_data_x70;
    end
  end

  // Pending-write lookup: output register is the oldest candidate, then queue
  // entries oldest to youngest so the last match is the youngest value.
  logic [PTR_W-1:0] lk_idx;
  always_comb begin
    lookup_hit_x70  = 1'b0;
    lookup_data_x70 = '0;
    lk_idx          = '0;
    if (wen_q && (wdest_q == lookup_addr_x70)) begin
      lookup_hit_x70  = 1'b1;
      lookup_data_x70 = wdata_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (dest_mem[lk_idx] == lookup_addr_x70)) begin
        lookup_hit_x70  = 1'b1;
        lookup_data_x70 = data_mem[lk_idx];
      end
    end
    if (lookup_addr_x70 == '0) begin
      lookup_hit_x70  = 1'b0;
      lookup_data_x70 = '0;
    end
  end

  assign stall_x70          = stall;
  assign reg_write_en_x70   = wen_q;
  assign reg_write_dest_x70 = wdest_q;
  assign reg_write_data_x70 = wdata_q;
  assign count_x70          = count_q;
  assign overflow_x70       = overflow_q;

endmodule
